// File: rtl/escalonador_preempcao_pkg.sv
// Shared definitions for the preemptive round-robin scheduler: FSM state
// encodings, the kernel slot index and the width of a program slot index.
package escalonador_preempcao_pkg;

    // Slot indices are 2 bits wide: kernel plus up to three user programs.
    localparam int PROG_W = 2;

    // Slot 0 always belongs to the kernel.
    localparam logic [PROG_W-1:0] KERNEL_SLOT = '0;

    typedef enum logic [1:0] {
        ESC_KERNEL = 2'd0,
        ESC_RUN    = 2'd1,
        ESC_SAVE   = 2'd2,
        ESC_PARADO = 2'd3
    } esc_estado_t;

endpackage

// File: rtl/escalonador_preempcao_tabela_pc.sv
// tabela_pc: N_PROGS x PC_W register file holding the saved PC of each slot.
// One synchronous write port, one combinational read port. Reads of a slot
// index outside 0..N_PROGS-1 return 0.
module tabela_pc
    import escalonador_preempcao_pkg::*;
#(
    parameter int N_PROGS = 3,
    parameter int PC_W    = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [PROG_W-1:0] i_waddr,
    input  logic [PC_W-1:0]   i_wdata,
    input  logic [PROG_W-1:0] i_raddr,
    output logic [PC_W-1:0]   o_rdata
);

    localparam logic [PROG_W:0] N_LIM = (PROG_W+1)'(N_PROGS);

    logic [PC_W-1:0] r_tabela [N_PROGS];
    logic            w_wr_ok;
    logic            w_rd_ok;

    assign w_wr_ok = ({1'b0, i_waddr} < N_LIM);
    assign w_rd_ok = ({1'b0, i_raddr} < N_LIM);

    // Synchronous write of a saved PC; reset clears every entry.
    always_ff @(posedge clock) begin
        // NOTE: this small table is reset on purpose because software reads
        // saved PCs of slots that may never have run; large RAMs would not be.
        if (reset) begin
            for (int i = 0; i < N_PROGS; i++) begin
                r_tabela[i] <= '0;
            end
        end else if (i_we && w_wr_ok) begin
            r_tabela[i_waddr] <= i_wdata;
        end
    end

    // Combinational read; a write in the same cycle is seen only after the edge.
    assign o_rdata = w_rd_ok ? r_tabela[i_raddr] : '0;

endmodule

// File: rtl/escalonador_preempcao.sv
// escalonador_preempcao: preemptive round-robin scheduler next to the control
// unit. The kernel (slot 0) dispatches user programs; each runs for QUANTUM
// enabled cycles or until HALT, then its PC is saved and the processor is
// forced back to the kernel entry through a one-cycle preempcao pulse.
// Optional feature macro: ESCALONADOR_RR_EN adds the prox_prog output with
// the next runnable slot after the last preempted one.
module escalonador_preempcao
    import escalonador_preempcao_pkg::*;
#(
    parameter int N_PROGS = 3,
    parameter int QUANTUM = 64,
    parameter int PC_W    = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            habilita,
    input  logic [PC_W-1:0] pc_atual,
    input  logic [1:0]      jump_prog,
    input  logic            jump_register,
    input  logic            reset_cont,
    input  logic            halt,
    input  logic [1:0]      prog_sel,
    output logic            preempcao,
    output logic [PC_W-1:0] pc_salvo,
    output logic [1:0]      prog_ativo,
    output logic [3:0]      concluidos,
`ifdef ESCALONADOR_RR_EN
    output logic [1:0]      prox_prog,
`endif
    output logic            parado
);

    localparam int              CNT_W   = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);
    localparam logic [PROG_W:0]  N_LIM   = (PROG_W+1)'(N_PROGS);

    esc_estado_t       r_estado;
    logic [CNT_W-1:0]  r_contador;
    logic              r_preempcao;
    logic [PROG_W-1:0] r_prog_ativo;
    logic [3:0]        r_concluidos;
    logic              r_parado;
    logic              w_jump_valido;
    logic              w_grava;

    // A kernel jump only counts when it names an existing user slot.
    assign w_jump_valido = jump_register && (jump_prog != KERNEL_SLOT) &&
                           ({1'b0, jump_prog} < N_LIM);

    // The PC of the interrupted program is captured during the SAVE cycle.
    assign w_grava = (r_estado == ESC_SAVE);

`ifdef ESCALONADOR_RR_EN
    logic [PROG_W-1:0] r_prox_prog;

    // First slot after 'atual' (wrapping N_PROGS-1 -> 1) not yet halted; 0 if none.
    function automatic logic [PROG_W-1:0] proximo_slot(input logic [PROG_W-1:0] atual,
                                                       input logic [3:0]        feitos);
        logic [PROG_W-1:0] escolha;
        logic              achou;
        int                idx;
        escolha = KERNEL_SLOT;
        achou   = 1'b0;
        for (int k = 1; k < N_PROGS; k++) begin
            idx = ((int'(atual) - 1 + k) % (N_PROGS - 1)) + 1;
            if (!achou && !feitos[idx]) begin
                escolha = idx[PROG_W-1:0];
                achou   = 1'b1;
            end
        end
        return escolha;
    endfunction

    assign prox_prog = r_prox_prog;
`endif

    // Scheduler FSM: state, quantum counter and all registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register in this block
        // sampling pre-edge values, so the order of statements does not matter.
        if (reset) begin
            r_estado     <= ESC_KERNEL;
            r_contador   <= '0;
            r_preempcao  <= 1'b0;
            r_prog_ativo <= KERNEL_SLOT;
            r_concluidos <= '0;
            r_parado     <= 1'b0;
`ifdef ESCALONADOR_RR_EN
            r_prox_prog  <= KERNEL_SLOT;
`endif
        end else begin
            case (r_estado)
                ESC_KERNEL: begin
                    r_contador <= '0;
                    if (halt) begin
                        r_estado <= ESC_PARADO;
                        r_parado <= 1'b1;
                    end else if (w_jump_valido) begin
                        r_estado                <= ESC_RUN;
                        r_prog_ativo            <= jump_prog;
                        r_concluidos[jump_prog] <= 1'b0;
                    end
                end
                ESC_RUN: begin
                    // Halt beats expiry so the program is recorded as finished.
                    if (halt) begin
                        r_concluidos[r_prog_ativo] <= 1'b1;
                        r_estado                   <= ESC_SAVE;
                        r_preempcao                <= 1'b1;
                        r_contador                 <= '0;
                    end else if (reset_cont) begin
                        r_contador <= '0;
                    end else if (habilita) begin
                        if (r_contador == CNT_MAX) begin
                            r_estado    <= ESC_SAVE;
                            r_preempcao <= 1'b1;
                            r_contador  <= '0;
                        end else begin
                            r_contador <= r_contador + CNT_W'(1);
                        end
                    end
                end
                ESC_SAVE: begin
                    r_estado     <= ESC_KERNEL;
                    r_preempcao  <= 1'b0;
                    r_prog_ativo <= KERNEL_SLOT;
                    r_contador   <= '0;
`ifdef ESCALONADOR_RR_EN
                    r_prox_prog  <= proximo_slot(r_prog_ativo, r_concluidos);
`endif
                end
                ESC_PARADO: begin
                    r_estado <= ESC_PARADO;
                end
                default: begin
                    r_estado <= ESC_KERNEL;
                end
            endcase
        end
    end

    tabela_pc #(
        .N_PROGS (N_PROGS),
        .PC_W    (PC_W)
    ) u_tabela_pc (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_grava),
        .i_waddr (r_prog_ativo),
        .i_wdata (pc_atual),
        .i_raddr (prog_sel),
        .o_rdata (pc_salvo)
    );

    assign preempcao  = r_preempcao;
    assign prog_ativo = r_prog_ativo;
    assign concluidos = r_concluidos;
    assign parado     = r_parado;

endmodule

// File: tb/tb_escalonador_preempcao.sv
// Directed testbench for escalonador_preempcao with default parameters
// (N_PROGS=3, QUANTUM=64, PC_W=10). Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, away from the edge.
module tb_escalonador_preempcao;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [9:0] pc_atual;
    logic [1:0] jump_prog;
    logic       jump_register;
    logic       reset_cont;
    logic       halt;
    logic [1:0] prog_sel;
    logic       preempcao;
    logic [9:0] pc_salvo;
    logic [1:0] prog_ativo;
    logic [3:0] concluidos;
    logic       parado;
`ifdef ESCALONADOR_RR_EN
    logic [1:0] prox_prog;
`endif

    int n_checks = 0;
    int n_errors = 0;

    escalonador_preempcao dut (
        .clock         (clock),
        .reset         (reset),
        .habilita      (habilita),
        .pc_atual      (pc_atual),
        .jump_prog     (jump_prog),
        .jump_register (jump_register),
        .reset_cont    (reset_cont),
        .halt          (halt),
        .prog_sel      (prog_sel),
        .preempcao     (preempcao),
        .pc_salvo      (pc_salvo),
        .prog_ativo    (prog_ativo),
        .concluidos    (concluidos),
`ifdef ESCALONADOR_RR_EN
        .prox_prog     (prox_prog),
`endif
        .parado        (parado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read a saved PC through the combinational port.
    task automatic ler_pc(input logic [1:0] sel, output logic [9:0] val);
        prog_sel = sel;
        #1;
        val = pc_salvo;
    endtask

    // Kernel issues jump P<p> for one cycle.
    task automatic lancar(input logic [1:0] p);
        jump_prog     = p;
        jump_register = 1'b1;
        tick();
        jump_register = 1'b0;
        jump_prog     = 2'd0;
    endtask

    // Ticks until preempcao is seen high, bounded to 300 cycles.
    task automatic ate_preempcao(output int ciclos);
        ciclos = 0;
        while (preempcao !== 1'b1 && ciclos < 300) begin
            tick();
            ciclos++;
        end
    endtask

    task automatic test_reset();
        logic [9:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (preempcao !== 1'b0) begin n_errors++; $display("FAIL reset_preempcao: got %b expected 0", preempcao); end
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL reset_prog_ativo: got %0d expected 0", prog_ativo); end
        n_checks++; if (concluidos !== 4'b0000) begin n_errors++; $display("FAIL reset_concluidos: got %b expected 0000", concluidos); end
        n_checks++; if (parado !== 1'b0) begin n_errors++; $display("FAIL reset_parado: got %b expected 0", parado); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h000) begin n_errors++; $display("FAIL reset_pc1: got %h expected 000", v); end
    endtask

    task automatic test_quantum();
        int ciclos;
        logic [9:0] v;
        habilita = 1'b1;
        pc_atual = 10'h040;
        lancar(2'd1);
        n_checks++; if (prog_ativo !== 2'd1) begin n_errors++; $display("FAIL q_prog_ativo_run: got %0d expected 1", prog_ativo); end
        ate_preempcao(ciclos);
        n_checks++; if (ciclos != 64) begin n_errors++; $display("FAIL q_latencia: got %0d cycles expected 64", ciclos); end
        n_checks++; if (prog_ativo !== 2'd1) begin n_errors++; $display("FAIL q_prog_ativo_save: got %0d expected 1", prog_ativo); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h000) begin n_errors++; $display("FAIL q_pc1_during_save: got %h expected 000", v); end
        tick();
        n_checks++; if (preempcao !== 1'b0) begin n_errors++; $display("FAIL q_pulse_width: got %b expected 0", preempcao); end
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL q_prog_ativo_kernel: got %0d expected 0", prog_ativo); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h040) begin n_errors++; $display("FAIL q_pc1_saved: got %h expected 040", v); end
        ler_pc(2'd3, v);
        n_checks++; if (v !== 10'h000) begin n_errors++; $display("FAIL q_pc3_out_of_range: got %h expected 000", v); end
    endtask

    task automatic test_halt();
        logic [9:0] v;
        pc_atual = 10'h123;
        lancar(2'd2);
        repeat (5) tick();
        jump_prog     = 2'd1;
        jump_register = 1'b1;
        tick();
        jump_register = 1'b0;
        jump_prog     = 2'd0;
        n_checks++; if (prog_ativo !== 2'd2) begin n_errors++; $display("FAIL h_jump_ignored_in_run: got %0d expected 2", prog_ativo); end
        repeat (4) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (preempcao !== 1'b1) begin n_errors++; $display("FAIL h_preempcao: got %b expected 1", preempcao); end
        n_checks++; if (concluidos !== 4'b0100) begin n_errors++; $display("FAIL h_concluidos: got %b expected 0100", concluidos); end
        tick();
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL h_prog_ativo: got %0d expected 0", prog_ativo); end
        ler_pc(2'd2, v);
        n_checks++; if (v !== 10'h123) begin n_errors++; $display("FAIL h_pc2_saved: got %h expected 123", v); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h040) begin n_errors++; $display("FAIL h_pc1_kept: got %h expected 040", v); end
    endtask

    task automatic test_halt_expiry();
        int pulsos;
        logic [9:0] v;
        pc_atual = 10'h155;
        lancar(2'd1);
        repeat (63) tick();
        n_checks++; if (preempcao !== 1'b0) begin n_errors++; $display("FAIL he_no_early_pulse: got %b expected 0", preempcao); end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (preempcao !== 1'b1) begin n_errors++; $display("FAIL he_preempcao: got %b expected 1", preempcao); end
        n_checks++; if (concluidos !== 4'b0110) begin n_errors++; $display("FAIL he_concluidos: got %b expected 0110", concluidos); end
        pulsos = 0;
        repeat (6) begin
            tick();
            if (preempcao === 1'b1) pulsos++;
        end
        n_checks++; if (pulsos != 0) begin n_errors++; $display("FAIL he_extra_pulses: got %0d expected 0", pulsos); end
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL he_prog_ativo: got %0d expected 0", prog_ativo); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h155) begin n_errors++; $display("FAIL he_pc1_saved: got %h expected 155", v); end
    endtask

    task automatic test_reset_cont_habilita();
        int ciclos;
        pc_atual = 10'h0AA;
        lancar(2'd1);
        n_checks++; if (concluidos !== 4'b0100) begin n_errors++; $display("FAIL rc_reload_clears: got %b expected 0100", concluidos); end
        repeat (60) tick();
        reset_cont = 1'b1;
        tick();
        reset_cont = 1'b0;
        ate_preempcao(ciclos);
        n_checks++; if (ciclos != 64) begin n_errors++; $display("FAIL rc_after_reset_cont: got %0d cycles expected 64", ciclos); end
        tick();
        lancar(2'd2);
        repeat (20) tick();
        habilita = 1'b0;
        repeat (5) tick();
        habilita = 1'b1;
        ate_preempcao(ciclos);
        n_checks++; if (ciclos != 44) begin n_errors++; $display("FAIL rc_habilita_freeze: got %0d cycles expected 44", ciclos); end
        tick();
        n_checks++; if (concluidos !== 4'b0000) begin n_errors++; $display("FAIL rc_concluidos: got %b expected 0000", concluidos); end
    endtask

    task automatic test_kernel_parado();
        int ruins;
        jump_prog     = 2'd3;
        jump_register = 1'b1;
        tick();
        jump_register = 1'b0;
        jump_prog     = 2'd0;
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL kp_slot3_ignored: got %0d expected 0", prog_ativo); end
        ruins = 0;
        repeat (70) begin
            tick();
            if (preempcao !== 1'b0 || prog_ativo !== 2'd0) ruins++;
        end
        n_checks++; if (ruins != 0) begin n_errors++; $display("FAIL kp_stays_kernel: got %0d bad cycles expected 0", ruins); end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (parado !== 1'b1) begin n_errors++; $display("FAIL kp_parado: got %b expected 1", parado); end
        lancar(2'd1);
        repeat (3) tick();
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL kp_frozen_prog: got %0d expected 0", prog_ativo); end
        n_checks++; if (parado !== 1'b1) begin n_errors++; $display("FAIL kp_parado_held: got %b expected 1", parado); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (parado !== 1'b0) begin n_errors++; $display("FAIL kp_reset_exit: got %b expected 0", parado); end
    endtask

    task automatic test_reset_in_save();
        logic [9:0] v;
        pc_atual = 10'h2AA;
        lancar(2'd1);
        repeat (63) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (preempcao !== 1'b1) begin n_errors++; $display("FAIL rs_in_save: got %b expected 1", preempcao); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (preempcao !== 1'b0) begin n_errors++; $display("FAIL rs_preempcao: got %b expected 0", preempcao); end
        n_checks++; if (prog_ativo !== 2'd0) begin n_errors++; $display("FAIL rs_prog_ativo: got %0d expected 0", prog_ativo); end
        n_checks++; if (concluidos !== 4'b0000) begin n_errors++; $display("FAIL rs_concluidos: got %b expected 0000", concluidos); end
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h000) begin n_errors++; $display("FAIL rs_pc1_not_saved: got %h expected 000", v); end
        tick();
        ler_pc(2'd1, v);
        n_checks++; if (v !== 10'h000) begin n_errors++; $display("FAIL rs_pc1_after: got %h expected 000", v); end
    endtask

`ifdef ESCALONADOR_RR_EN
    task automatic test_round_robin();
        int ciclos;
        lancar(2'd2);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        lancar(2'd1);
        ate_preempcao(ciclos);
        tick();
        n_checks++; if (prox_prog !== 2'd1) begin n_errors++; $display("FAIL rr_p2_done: got %0d expected 1", prox_prog); end
        lancar(2'd1);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        n_checks++; if (prox_prog !== 2'd0) begin n_errors++; $display("FAIL rr_all_done: got %0d expected 0", prox_prog); end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        habilita      = 1'b0;
        pc_atual      = '0;
        jump_prog     = '0;
        jump_register = 1'b0;
        reset_cont    = 1'b0;
        halt          = 1'b0;
        prog_sel      = '0;
        test_reset();
        test_quantum();
        test_halt();
        test_halt_expiry();
        test_reset_cont_habilita();
        test_kernel_parado();
        test_reset_in_save();
`ifdef ESCALONADOR_RR_EN
        test_round_robin();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
